// File: rtl/elevator_scheduler.sv
// SCAN car controller: serves latched floor requests, one floor per TRAVEL_CYCLES.
// Latency: a request is sampled every cycle; stop decisions take effect on the same edge as arrival.
// Backpressure: none; requests stay in their external latches until the one-cycle Done pulse for that floor.
//
// Ports:
//   Clock      system clock, posedge
//   Reset      synchronous, active-high
//   req        latched floor requests, bit i = floor i pending
//   door_hold  (only with DOOR_HOLD_EN defined) freezes door dwell while high in DOOR
//   Done       one-hot, one-cycle pulse clearing the serviced floor's request latch
//   cur_floor  current or last-passed floor
//   dir_up     1 = travelling up / last went up, 0 = down
//   moving     car is travelling between floors
//   door_open  door open at cur_floor
//
// Optional feature macro: DOOR_HOLD_EN (adds the door_hold input).

module elevator_scheduler #(
  parameter int NUM_FLOORS    = 6,
  parameter int TRAVEL_CYCLES = 50,
  parameter int DOOR_CYCLES   = 100
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [NUM_FLOORS-1:0]         req,
`ifdef DOOR_HOLD_EN
  input  logic                          door_hold,
`endif
  output logic [NUM_FLOORS-1:0]         Done,
  output logic [$clog2(NUM_FLOORS)-1:0] cur_floor,
  output logic                          dir_up,
  output logic                          moving,
  output logic                          door_open
);

  localparam int FW = $clog2(NUM_FLOORS);
  localparam int TW = $clog2(TRAVEL_CYCLES);
  localparam int DW = $clog2(DOOR_CYCLES);

  localparam logic [TW-1:0]         TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0]         DOOR_LAST   = DW'(DOOR_CYCLES - 1);
  // Dwell counts below this ignore req[cur_floor]: the latch is still clearing.
  localparam logic [DW-1:0]         REOPEN_MIN  = DW'(2);
  localparam logic [NUM_FLOORS-1:0] ONE_HOT0    = NUM_FLOORS'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [FW-1:0]           cur_floor_q, cur_floor_d;
  logic                    dir_up_q, dir_up_d;
  logic [TW-1:0]           travel_q, travel_d;
  logic [DW-1:0]           dwell_q, dwell_d;
  logic [NUM_FLOORS-1:0]   done_q, done_d;
  logic                    moving_q, door_open_q;

  logic [FW-1:0]           next_floor;
  logic [FW-1:0]           eval_floor;
  logic                    req_here, req_above, req_below;
  logic                    req_ahead, req_behind;
  logic                    hold;

`ifdef DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  // Floor the car reaches at the end of the current travel segment.
  assign next_floor = dir_up_q ? (cur_floor_q + FW'(1)) : (cur_floor_q - FW'(1));

  // The decision is taken against the arrival floor while moving, and
  // against the standing floor otherwise.
  assign eval_floor = (state_q == MOVE) ? next_floor : cur_floor_q;

  // Request classification relative to eval_floor. The top floor has no
  // "above" set and floor 0 no "below" set, so reversal at the ends falls out.
  always_comb begin
    req_here  = 1'b0;
    req_above = 1'b0;
    req_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (req[i]) begin
        if (FW'(i) == eval_floor) req_here  = 1'b1;
        if (FW'(i) >  eval_floor) req_above = 1'b1;
        if (FW'(i) <  eval_floor) req_below = 1'b1;
      end
    end
  end

  assign req_ahead  = dir_up_q ? req_above : req_below;
  assign req_behind = dir_up_q ? req_below : req_above;

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    dir_up_d    = dir_up_q;
    travel_d    = travel_q;
    dwell_d     = dwell_q;
    done_d      = '0;

    unique case (state_q)
      IDLE: begin
        if (req_here) begin
          state_d = DOOR;
          dwell_d = '0;
          done_d  = ONE_HOT0 << eval_floor;
        end else if (req_ahead) begin
          state_d  = MOVE;
          travel_d = '0;
        end else if (req_behind) begin
          state_d  = MOVE;
          dir_up_d = ~dir_up_q;
          travel_d = '0;
        end
      end

      MOVE: begin
        if (travel_q == TRAVEL_LAST) begin
          // Arrival: floor step and stop/continue/reverse decision share the edge.
          cur_floor_d = next_floor;
          travel_d    = '0;
          if (req_here) begin
            state_d = DOOR;
            dwell_d = '0;
            done_d  = ONE_HOT0 << eval_floor;
          end else if (req_ahead) begin
            state_d = MOVE;
          end else if (req_behind) begin
            state_d  = MOVE;
            dir_up_d = ~dir_up_q;
          end else begin
            state_d = IDLE;
          end
        end else begin
          travel_d = travel_q + TW'(1);
        end
      end

      DOOR: begin
        if (req_here && (dwell_q >= REOPEN_MIN)) begin
          // Fresh call at this floor while the door is open: re-open.
          dwell_d = '0;
          done_d  = ONE_HOT0 << eval_floor;
        end else if (hold) begin
          dwell_d = dwell_q;
        end else if (dwell_q == DOOR_LAST) begin
          // Always pass through IDLE before the next move.
          state_d = IDLE;
          dwell_d = '0;
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      cur_floor_q <= '0;
      dir_up_q    <= 1'b1;
      travel_q    <= '0;
      dwell_q     <= '0;
      done_q      <= '0;
      moving_q    <= 1'b0;
      door_open_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_floor_q <= cur_floor_d;
      dir_up_q    <= dir_up_d;
      travel_q    <= travel_d;
      dwell_q     <= dwell_d;
      done_q      <= done_d;
      moving_q    <= (state_d == MOVE);
      door_open_q <= (state_d == DOOR);
    end
  end

  assign Done      = done_q;
  assign cur_floor = cur_floor_q;
  assign dir_up    = dir_up_q;
  assign moving    = moving_q;
  assign door_open = door_open_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: directed table, hand sequences and random requests vs a reference model.
// Latency: one model step per clock edge, outputs compared 1 time unit after the edge.
// Backpressure: the bench plays the floor request latches, clearing a bit on the cycle after Done.

module tb_elevator_scheduler;

  localparam int N  = 6;
  localparam int T  = 4;
  localparam int D  = 6;

  logic         Clock;
  logic         Reset;
  logic [N-1:0] req;
  logic [N-1:0] Done;
  logic [2:0]   cur_floor;
  logic         dir_up;
  logic         moving;
  logic         door_open;
`ifdef DOOR_HOLD_EN
  logic         door_hold;
`endif

  elevator_scheduler #(
    .NUM_FLOORS   (N),
    .TRAVEL_CYCLES(T),
    .DOOR_CYCLES  (D)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .req      (req),
`ifdef DOOR_HOLD_EN
    .door_hold(door_hold),
`endif
    .Done     (Done),
    .cur_floor(cur_floor),
    .dir_up   (dir_up),
    .moving   (moving),
    .door_open(door_open)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: car position, heading, activity and time spent in it.
  localparam int M_IDLE = 0;
  localparam int M_MOVE = 1;
  localparam int M_DOOR = 2;
  int           m_floor;
  bit           m_up;
  int           m_mode;
  int           m_time;
  logic [N-1:0] m_done;

  int age [N];
  int max_age = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // SCAN choice at the model's current floor: stop here, keep heading, turn, or rest.
  task automatic m_choose(input logic [N-1:0] r);
    bit above = 0;
    bit below = 0;
    for (int f = 0; f < N; f++) begin
      if (r[f] && f > m_floor) above = 1;
      if (r[f] && f < m_floor) below = 1;
    end
    m_time = 0;
    if (r[m_floor]) begin
      m_mode = M_DOOR;
      m_done[m_floor] = 1'b1;
    end else if (m_up ? above : below) begin
      m_mode = M_MOVE;
    end else if (m_up ? below : above) begin
      m_up   = !m_up;
      m_mode = M_MOVE;
    end else begin
      m_mode = M_IDLE;
    end
  endtask

  task automatic m_step(input logic [N-1:0] r, input logic rst, input logic hold);
    m_done = '0;
    if (rst) begin
      m_floor = 0; m_up = 1; m_mode = M_IDLE; m_time = 0;
    end else if (m_mode == M_IDLE) begin
      m_choose(r);
    end else if (m_mode == M_MOVE) begin
      m_time++;
      if (m_time == T) begin
        m_floor = m_up ? m_floor + 1 : m_floor - 1;
        m_choose(r);
      end
    end else begin
      if (m_time >= 2 && r[m_floor]) begin
        m_time = 0;
        m_done[m_floor] = 1'b1;
      end else if (!hold) begin
        m_time++;
        if (m_time == D) m_mode = M_IDLE;
      end
    end
  endtask

  // One clock: post new calls, step the model, clear latches hit by last Done, compare.
  task automatic tick(input logic [N-1:0] newreq);
    logic [N-1:0] d_prev;
    logic         h;
    logic [11:0]  exp_v, act_v;
    h = 1'b0;
`ifdef DOOR_HOLD_EN
    h = door_hold;
`endif
    d_prev = Done;
    req = req | newreq;
    m_step(req, Reset, h);
    @(posedge Clock);
    #1;
    req = req & ~(d_prev & ~newreq);
    for (int f = 0; f < N; f++) begin
      age[f] = req[f] ? age[f] + 1 : 0;
      if (age[f] > max_age) max_age = age[f];
    end
    exp_v = {3'(m_floor), m_up, (m_mode == M_MOVE), (m_mode == M_DOOR), m_done};
    act_v = {cur_floor, dir_up, moving, door_open, Done};
    chk("model {floor,dir,moving,door,Done}", 32'(act_v), 32'(exp_v));
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    req   = '0;
    tick('0);
    tick('0);
    Reset = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int k = 0; k < 300; k++) begin
      tick('0);
      if (Done != '0) begin ok = 1; break; end
    end
    chk("wait_done timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 300; k++) begin
      if (!moving && !door_open) begin ok = 1; break; end
      tick('0);
    end
    chk("wait_idle timeout", 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic [N-1:0] newreq;
    logic [2:0]   floor;
    logic         mv;
    logic         door;
    logic [N-1:0] done;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int cnt;
    Reset = 1'b1;
    req   = '0;
    for (int f = 0; f < N; f++) age[f] = 0;
`ifdef DOOR_HOLD_EN
    door_hold = 1'b0;
`endif

    // Single call to floor 2 from reset: travel 4 cycles per floor, 6-cycle dwell.
    for (int i = 0; i < 16; i++) tbl[i] = '{newreq: '0, floor: 3'd0, mv: 1'b1, door: 1'b0, done: '0};
    tbl[0].newreq = 6'b000100;
    for (int i = 4; i < 8; i++) tbl[i].floor = 3'd1;
    for (int i = 8; i < 16; i++) begin
      tbl[i].floor = 3'd2; tbl[i].mv = 1'b0; tbl[i].door = (i < 14);
    end
    tbl[8].done = 6'b000100;

    do_reset();
    chk("reset cur_floor", 32'(cur_floor), 32'd0);
    chk("reset dir_up", 32'(dir_up), 32'd1);
    chk("reset moving/door", 32'({moving, door_open}), 32'd0);
    chk("reset Done", 32'(Done), 32'd0);

    for (int i = 0; i < 16; i++) begin
      tick(tbl[i].newreq);
      chk($sformatf("table[%0d]", i), 32'({cur_floor, moving, door_open, Done}),
          32'({tbl[i].floor, tbl[i].mv, tbl[i].door, tbl[i].done}));
    end

    // Call at the standing floor: immediate stop, no motion.
    do_reset();
    tick(6'b000001);
    chk("idle call Done", 32'(Done), 32'b000001);
    chk("idle call door/moving", 32'({door_open, moving}), 32'b10);

    // Pick up a mid-travel call ahead of the target without reversing.
    do_reset();
    tick(6'b000010);
    wait_done();
    wait_idle();
    tick(6'b010000);
    tick('0);
    tick('0);
    tick(6'b001000);
    wait_done();
    chk("mid-travel stop Done", 32'(Done), 32'b001000);
    chk("mid-travel stop floor", 32'(cur_floor), 32'd3);
    wait_done();
    chk("continue Done", 32'(Done), 32'b010000);
    chk("continue dir_up", 32'(dir_up), 32'd1);

    // Heading down from 3 with calls at both ends: bottom first, then top.
    do_reset();
    tick(6'b100000);
    wait_done();
    wait_idle();
    tick(6'b001000);
    wait_done();
    chk("down to 3 floor", 32'(cur_floor), 32'd3);
    chk("down to 3 dir_up", 32'(dir_up), 32'd0);
    wait_idle();
    tick(6'b100001);
    wait_done();
    chk("scan first stop", 32'(Done), 32'b000001);
    wait_done();
    chk("scan second stop", 32'(Done), 32'b100000);
    chk("scan second dir_up", 32'(dir_up), 32'd1);

    // Re-open at dwell 4, then 6 more door cycles.
    do_reset();
    tick(6'b000100);
    wait_done();
    for (int i = 0; i < 4; i++) tick('0);
    tick(6'b000100);
    chk("reopen Done", 32'(Done), 32'b000100);
    cnt = 0;
    for (int i = 0; i < 20 && door_open; i++) begin
      cnt++;
      tick('0);
    end
    chk("reopen door cycles", 32'(cnt), 32'd6);

    // Reset mid-move.
    do_reset();
    tick(6'b100000);
    for (int i = 0; i < 5; i++) tick('0);
    Reset = 1'b1;
    tick('0);
    Reset = 1'b0;
    chk("mid-move reset", 32'({cur_floor, moving, door_open, Done}), 32'd0);
    req = '0;

`ifdef DOOR_HOLD_EN
    // Hold for 10 cycles: 16 door-open cycles in total.
    do_reset();
    tick(6'b000100);
    wait_done();
    cnt = 1;
    door_hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick('0);
      if (door_open) cnt++;
    end
    door_hold = 1'b0;
    for (int i = 0; i < 20 && door_open; i++) begin
      tick('0);
      if (door_open) cnt++;
    end
    chk("door_hold open cycles", 32'(cnt), 32'd16);
`endif

    // Random calls against the model.
    do_reset();
    for (int f = 0; f < N; f++) age[f] = 0;
    max_age = 0;
    for (int i = 0; i < 4000; i++) begin
      logic [N-1:0] nr;
      nr = '0;
      if ($urandom_range(0, 7) == 0) nr[$urandom_range(0, N - 1)] = 1'b1;
`ifdef DOOR_HOLD_EN
      door_hold = ($urandom_range(0, 15) == 0);
`endif
      tick(nr);
    end
    chk("max pending age bounded", 32'(max_age <= 1000), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
